// File: rtl/bram_arb_pkg.sv
// Shared types and default sizing for the two-requester BRAM port-A arbiter.
//   req_id_t : requester identity (REQ0 / REQ1)
//   rd_tag_t : in-flight read tag (valid + owner), carried alongside BRAM latency
//   AW_DEF / DW_DEF / RD_LAT_DEF : default address width, data width, read latency
package bram_arb_pkg;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t owner;
    } rd_tag_t;

    localparam int unsigned AW_DEF     = 10;
    localparam int unsigned DW_DEF     = 32;
    localparam int unsigned RD_LAT_DEF = 2;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Bundle of the requester-side handshake signals and the BRAM port-A signals
// served by bram_port_arbiter.
//   master : the parent side (requesters drive req/we/addr/wdata, BRAM drives bram_rd_data)
//   slave  : the arbiter side (drives ack, rd_valid, rd_data and the BRAM command)
interface bram_port_arbiter_if
    import bram_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);

    logic          req_0;
    logic          req_1;
    logic          we_0;
    logic          we_1;
    logic [AW-1:0] addr_0;
    logic [AW-1:0] addr_1;
    logic [DW-1:0] wdata_0;
    logic [DW-1:0] wdata_1;
    logic          ack_0;
    logic          ack_1;
    logic          rd_valid_0;
    logic          rd_valid_1;
    logic [DW-1:0] rd_data;

    logic          bram_we;
    logic          bram_en_a;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wr_data;
    logic [DW-1:0] bram_rd_data;

    modport master (
        output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1,
        output bram_rd_data,
        input  ack_0, ack_1, rd_valid_0, rd_valid_1, rd_data,
        input  bram_we, bram_en_a, bram_addr, bram_wr_data
    );

    modport slave (
        input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1,
        input  bram_rd_data,
        output ack_0, ack_1, rd_valid_0, rd_valid_1, rd_data,
        output bram_we, bram_en_a, bram_addr, bram_wr_data
    );

endinterface

// File: rtl/bram_rd_tag_pipe.sv
// Delay line that carries a read tag for RD_LAT cycles so it emerges in the
// same cycle as the matching bram_rd_data. Synchronous clear drops every
// in-flight tag.
//   clk, rst : clock, synchronous active-high clear
//   tag_in   : tag launched together with the BRAM command
//   tag_out  : tag aligned with valid bram_rd_data
module bram_rd_tag_pipe
    import bram_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [RD_LAT-1:0] stage;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port A between two requesters.
// One request is acknowledged per cycle (combinational ack), the winning
// command is registered onto the BRAM port the next cycle, and read results
// are returned RD_LAT+2 cycles after ack on the shared rd_data with a
// one-cycle rd_valid pulse for the owner.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester handshake + BRAM port-A signals (slave modport)
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    bram_port_arbiter_if.slave bus
);

    logic          grant_0;
    logic          grant_1;
    req_id_t       prio;
    req_id_t       sel_owner;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic          cmd_en;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    rd_tag_t       issue_tag;
    rd_tag_t       ret_tag;

    logic [DW-1:0] rd_data_q;
    logic          rd_valid_0_q;
    logic          rd_valid_1_q;

    // prio names the requester that wins a tie.
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (!rst) begin
            grant_0 = bus.req_0 && (!bus.req_1 || prio == REQ0);
            grant_1 = bus.req_1 && (!bus.req_0 || prio == REQ1);
        end
    end

    always_comb begin
        sel_owner = REQ0;
        sel_we    = bus.we_0;
        sel_addr  = bus.addr_0;
        sel_wdata = bus.wdata_0;
        if (grant_1) begin
            sel_owner = REQ1;
            sel_we    = bus.we_1;
            sel_addr  = bus.addr_1;
            sel_wdata = bus.wdata_1;
        end
    end

    // issue_tag is registered with the command so it sits in the same cycle
    // as bram_en_a; the tag pipe then adds exactly the BRAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio      <= REQ0;
            cmd_en    <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            issue_tag <= '0;
        end else if (grant_0 || grant_1) begin
            prio            <= grant_0 ? REQ1 : REQ0;
            cmd_en          <= 1'b1;
            cmd_we          <= sel_we;
            cmd_addr        <= sel_addr;
            cmd_wdata       <= sel_wdata;
            issue_tag.valid <= !sel_we;
            issue_tag.owner <= sel_owner;
        end else begin
            cmd_en    <= 1'b0;
            cmd_we    <= 1'b0;
            issue_tag <= '0;
        end
    end

    bram_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (issue_tag),
        .tag_out (ret_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q    <= '0;
            rd_valid_0_q <= 1'b0;
            rd_valid_1_q <= 1'b0;
        end else begin
            rd_valid_0_q <= ret_tag.valid && ret_tag.owner == REQ0;
            rd_valid_1_q <= ret_tag.valid && ret_tag.owner == REQ1;
            if (ret_tag.valid) begin
                rd_data_q <= bus.bram_rd_data;
            end
        end
    end

    assign bus.ack_0        = grant_0;
    assign bus.ack_1        = grant_1;
    assign bus.bram_en_a    = cmd_en;
    assign bus.bram_we      = cmd_we;
    assign bus.bram_addr    = cmd_addr;
    assign bus.bram_wr_data = cmd_wdata;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid_0   = rd_valid_0_q;
    assign bus.rd_valid_1   = rd_valid_1_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural RD_LAT=2 BRAM.
module tb_bram_port_arbiter;

    localparam int unsigned AW     = 10;
    localparam int unsigned DW     = 32;
    localparam int unsigned RD_LAT = 2;

    typedef struct {
        int          cyc;
        logic        id;
        logic [31:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_checks = 0;
    int n_pass   = 0;
    int both_ack = 0;

    ev_t ack_q[$];
    ev_t rv_q[$];

    logic [DW-1:0] mem [1024];
    logic [DW-1:0] bram_p0;
    logic [DW-1:0] bram_p1;

    bram_port_arbiter_if #(.AW(AW), .DW(DW)) bif ();

    bram_port_arbiter #(
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Two-register BRAM model: data for a command in cycle C appears in C+2.
    always @(posedge clk) begin
        if (bif.bram_en_a) begin
            if (bif.bram_we) mem[bif.bram_addr] <= bif.bram_wr_data;
            bram_p0 <= mem[bif.bram_addr];
        end
        bram_p1 <= bram_p0;
    end
    assign bif.bram_rd_data = bram_p1;

    always @(negedge clk) begin
        if (bif.ack_0 && bif.ack_1) both_ack++;
        if (bif.ack_0) ack_q.push_back('{cyc, 1'b0, 32'h0});
        if (bif.ack_1) ack_q.push_back('{cyc, 1'b1, 32'h0});
        if (bif.rd_valid_0) rv_q.push_back('{cyc, 1'b0, bif.rd_data});
        if (bif.rd_valid_1) rv_q.push_back('{cyc, 1'b1, bif.rd_data});
    end

    function automatic logic [31:0] init_word(input int a);
        return 32'hA5A5_0000 | 32'(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_en"},    32'(bif.bram_en_a),    32'h0);
        check({tag, "_we"},    32'(bif.bram_we),      32'h0);
        check({tag, "_addr"},  32'(bif.bram_addr),    32'h0);
        check({tag, "_wdata"}, bif.bram_wr_data,      32'h0);
        check({tag, "_rdata"}, bif.rd_data,           32'h0);
        check({tag, "_rv0"},   32'(bif.rd_valid_0),   32'h0);
        check({tag, "_rv1"},   32'(bif.rd_valid_1),   32'h0);
    endtask

    task automatic check_ack(input string tag, input int idx, input int exp_cyc, input logic exp_id);
        check($sformatf("%s_ack%0d_cyc", tag, idx), 32'(ack_q[idx].cyc), 32'(exp_cyc));
        check($sformatf("%s_ack%0d_id", tag, idx), 32'(ack_q[idx].id), 32'(exp_id));
    endtask

    task automatic check_rv(input string tag, input int idx, input int exp_cyc,
                            input logic exp_id, input logic [31:0] exp_data);
        check($sformatf("%s_rv%0d_cyc", tag, idx), 32'(rv_q[idx].cyc), 32'(exp_cyc));
        check($sformatf("%s_rv%0d_id", tag, idx), 32'(rv_q[idx].id), 32'(exp_id));
        check($sformatf("%s_rv%0d_data", tag, idx), rv_q[idx].data, exp_data);
    endtask

    initial begin
        int s;
        int n;
        int w;
        int r;
        int t;

        for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
        mem[5] = 32'hDEAD_BEEF;

        bif.req_0 = 1'b1;  bif.req_1 = 1'b1;
        bif.we_0 = 1'b0;   bif.we_1 = 1'b0;
        bif.addr_0 = 10'h010; bif.addr_1 = 10'h020;
        bif.wdata_0 = '0;  bif.wdata_1 = '0;

        // Reset with both requests already pending.
        step();
        #1;
        check("rst_ack0", 32'(bif.ack_0), 32'h0);
        check("rst_ack1", 32'(bif.ack_1), 32'h0);
        check_idle_outputs("rst");
        step();
        step();

        // Contention straight out of reset: 0,1,0,1.
        ack_q.delete(); rv_q.delete();
        rst = 1'b0;
        s = cyc;
        #1;
        check("post_rst_ack0", 32'(bif.ack_0), 32'h1);
        check("post_rst_ack1", 32'(bif.ack_1), 32'h0);
        step();
        check("cont_en",   32'(bif.bram_en_a), 32'h1);
        check("cont_addr", 32'(bif.bram_addr), 32'h010);
        check("cont_ack1", 32'(bif.ack_1),     32'h1);
        step(); step(); step();
        bif.req_0 = 1'b0; bif.req_1 = 1'b0;
        repeat (6) step();
        check("cont_ack_n", 32'(ack_q.size()), 32'd4);
        check("cont_rv_n",  32'(rv_q.size()),  32'd4);
        for (int i = 0; i < 4 && i < ack_q.size(); i++)
            check_ack("cont", i, s + i, logic'(i % 2));
        for (int i = 0; i < 4 && i < rv_q.size(); i++)
            check_rv("cont", i, s + i + 4, logic'(i % 2),
                     (i % 2 == 0) ? init_word(16'h010) : init_word(16'h020));

        // Single read of 0x005.
        ack_q.delete(); rv_q.delete();
        bif.req_0 = 1'b1; bif.we_0 = 1'b0; bif.addr_0 = 10'h005;
        n = cyc;
        #1;
        check("single_ack0", 32'(bif.ack_0), 32'h1);
        step();
        bif.req_0 = 1'b0; bif.addr_0 = 10'h3AA;
        check("single_en",   32'(bif.bram_en_a), 32'h1);
        check("single_we",   32'(bif.bram_we),   32'h0);
        check("single_addr", 32'(bif.bram_addr), 32'h005);
        step();
        check("idle_en",        32'(bif.bram_en_a), 32'h0);
        check("idle_addr_hold", 32'(bif.bram_addr), 32'h005);
        repeat (6) step();
        check("single_ack_n", 32'(ack_q.size()), 32'd1);
        check("single_rv_n",  32'(rv_q.size()),  32'd1);
        if (ack_q.size() > 0) check_ack("single", 0, n, 1'b0);
        if (rv_q.size() > 0) check_rv("single", 0, n + RD_LAT + 2, 1'b0, 32'hDEAD_BEEF);
        check("rd_data_hold", bif.rd_data, 32'hDEAD_BEEF);

        // Write 0x3FF from requester 1, then read it back from requester 0.
        ack_q.delete(); rv_q.delete();
        bif.req_1 = 1'b1; bif.we_1 = 1'b1; bif.addr_1 = 10'h3FF; bif.wdata_1 = 32'h1234_5678;
        w = cyc;
        #1;
        check("wr_ack1", 32'(bif.ack_1), 32'h1);
        step();
        bif.req_1 = 1'b0; bif.we_1 = 1'b0;
        bif.req_0 = 1'b1; bif.we_0 = 1'b0; bif.addr_0 = 10'h3FF;
        #1;
        check("wr_bram_we",    32'(bif.bram_we),   32'h1);
        check("wr_bram_addr",  32'(bif.bram_addr), 32'h3FF);
        check("wr_bram_wdata", bif.bram_wr_data,   32'h1234_5678);
        check("rd_after_wr_ack0", 32'(bif.ack_0),  32'h1);
        step();
        bif.req_0 = 1'b0;
        repeat (7) step();
        check("wr_ack_n", 32'(ack_q.size()), 32'd2);
        check("wr_rv_n",  32'(rv_q.size()),  32'd1);
        if (ack_q.size() > 1) begin
            check_ack("wr", 0, w, 1'b1);
            check_ack("wr", 1, w + 1, 1'b0);
        end
        if (rv_q.size() > 0) check_rv("wr", 0, w + 5, 1'b0, 32'h1234_5678);

        // Three reads in flight, then a one-cycle reset.
        ack_q.delete(); rv_q.delete();
        bif.req_0 = 1'b1; bif.addr_0 = 10'h030;
        r = cyc;
        step(); bif.addr_0 = 10'h031;
        step(); bif.addr_0 = 10'h032;
        step();
        rst = 1'b1; bif.req_1 = 1'b1; bif.addr_0 = 10'h040; bif.addr_1 = 10'h050;
        #1;
        check("midrst_ack0", 32'(bif.ack_0), 32'h0);
        check("midrst_ack1", 32'(bif.ack_1), 32'h0);
        step();
        rst = 1'b0;
        #1;
        check_idle_outputs("midrst");
        check("midrst_prio_ack0", 32'(bif.ack_0), 32'h1);
        check("midrst_prio_ack1", 32'(bif.ack_1), 32'h0);
        step();
        bif.req_0 = 1'b0; bif.req_1 = 1'b0;
        check("midrst_rv0_late",  32'(bif.rd_valid_0), 32'h0);
        check("midrst_rdata_late", bif.rd_data,        32'h0);
        repeat (6) step();
        check("midrst_ack_n", 32'(ack_q.size()), 32'd4);
        check("midrst_rv_n",  32'(rv_q.size()),  32'd1);
        if (ack_q.size() > 3) begin
            for (int i = 0; i < 3; i++) check_ack("midrst", i, r + i, 1'b0);
            check_ack("midrst", 3, r + 4, 1'b0);
        end
        if (rv_q.size() > 0) check_rv("midrst", 0, r + 8, 1'b0, init_word(16'h040));

        // Streaming 256 back-to-back reads from requester 0.
        ack_q.delete(); rv_q.delete();
        t = cyc;
        bif.req_0 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bif.addr_0 = 10'(16'h100 + i);
            step();
        end
        bif.req_0 = 1'b0;
        repeat (6) step();
        check("stream_ack_n", 32'(ack_q.size()), 32'd256);
        check("stream_rv_n",  32'(rv_q.size()),  32'd256);
        for (int i = 0; i < 256 && i < rv_q.size(); i++)
            check_rv("stream", i, t + i + 4, 1'b0, init_word(16'h100 + i));

        check("one_ack_per_cycle", 32'(both_ack), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
